// File: rtl/axi_sram_pkg.sv
// Shared types and address decode for the AXI-lite SRAM responder.
// Both FSM encodings live here so the bench and RTL agree on names.
package axi_sram_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    typedef enum logic [2:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_MEM,
        W_RESP
    } wr_state_e;

    typedef struct packed {
        logic              ok;
        logic [ADDR_W-1:0] idx;
    } decode_t;

    // Compare on the word offset, so a window near the top of the space cannot wrap.
    function automatic decode_t in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base,
                                         input logic [ADDR_W-1:0] depth);
        decode_t           d;
        logic [ADDR_W-1:0] word;
        word  = (addr - base) >> 3;
        d.ok  = (addr >= base) && (word < depth);
        d.idx = word;
        return d;
    endfunction

endpackage

// File: rtl/sram_sp_bw.sv
// Single-port byte-writable SRAM with synchronous, registered read.
// The output register only moves on a read, so it holds across writes.
module sram_sp_bw
    import axi_sram_pkg::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [STRB_W-1:0] be_i,
    output logic [DATA_W-1:0] rdata_o
);

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [7:0] mem_q [DEPTH];
        logic [7:0] rdata_q;

        always_ff @(posedge clk_i) begin
            if (en_i && we_i && be_i[gi]) begin
                mem_q[addr_i] <= wdata_i[8*gi +: 8];
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rdata_q <= '0;
            end else if (en_i && !we_i) begin
                rdata_q <= mem_q[addr_i];
            end
        end

        assign rdata_o[8*gi +: 8] = rdata_q;
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-lite SRAM responder: independent read/write handshake FSMs sharing
// one array port, with the write winning any same-cycle conflict.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          RD_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] axi_AW_ADDR,
    input  logic        axi_AW_VALID,
    output logic        axi_AW_READY,
    input  logic [63:0] axi_W_DATA,
    input  logic [7:0]  axi_W_STRB,
    input  logic        axi_W_VALID,
    output logic        axi_W_READY,
    output logic        axi_B_VALID,
    input  logic        axi_B_READY,
    input  logic [63:0] axi_AR_ADDR,
    input  logic        axi_AR_VALID,
    output logic        axi_AR_READY,
    output logic [63:0] axi_R_DATA,
    output logic        axi_R_VALID,
    input  logic        axi_R_READY,
    output logic        oob_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    rd_state_e         rd_state_q, rd_state_d;
    wr_state_e         wr_state_q, wr_state_d;
    logic [3:0]        rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              rd_ok_q, rd_ok_d;
    logic              wr_ok_q, wr_ok_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [STRB_W-1:0] wr_strb_q, wr_strb_d;

    decode_t           ar_dec, aw_dec;
    logic              ar_hs, aw_hs, w_hs;
    logic              wr_mem, rd_issue;
    logic              mem_en;
    logic [IDX_W-1:0]  mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_idx_hi;

    assign ar_dec        = in_range(axi_AR_ADDR, BASE_ADDR, 64'(DEPTH_WORDS));
    assign aw_dec        = in_range(axi_AW_ADDR, BASE_ADDR, 64'(DEPTH_WORDS));
    assign unused_idx_hi = ^{ar_dec.idx[ADDR_W-1:IDX_W], aw_dec.idx[ADDR_W-1:IDX_W]};

    assign ar_hs = axi_AR_VALID && axi_AR_READY;
    assign aw_hs = axi_AW_VALID && axi_AW_READY;
    assign w_hs  = axi_W_VALID && axi_W_READY;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            wr_state_q <= W_IDLE;
            rd_cnt_q   <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            rd_ok_q    <= 1'b1;
            wr_ok_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            rd_ok_q    <= rd_ok_d;
            wr_ok_q    <= wr_ok_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_idx_d   = rd_idx_q;
        rd_ok_d    = rd_ok_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = R_WAIT;
                    rd_cnt_d   = 4'(RD_LATENCY - 1);
                    rd_idx_d   = ar_dec.idx[IDX_W-1:0];
                    rd_ok_d    = ar_dec.ok;
                end
            end
            R_WAIT: begin
                // At zero the read only proceeds once the write has released the port.
                if (rd_cnt_q != 4'd0) begin
                    rd_cnt_d = rd_cnt_q - 4'd1;
                end else if (rd_issue) begin
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (axi_R_READY) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_ok_d    = wr_ok_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        if (aw_hs) begin
            wr_idx_d = aw_dec.idx[IDX_W-1:0];
            wr_ok_d  = aw_dec.ok;
        end
        if (w_hs) begin
            wr_data_d = axi_W_DATA;
            wr_strb_d = axi_W_STRB;
        end
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) wr_state_d = W_MEM;
                else if (aw_hs)    wr_state_d = W_HAVE_AW;
                else if (w_hs)     wr_state_d = W_HAVE_W;
            end
            W_HAVE_AW: if (w_hs)  wr_state_d = W_MEM;
            W_HAVE_W:  if (aw_hs) wr_state_d = W_MEM;
            W_MEM:     wr_state_d = W_RESP;
            W_RESP:    if (axi_B_READY) wr_state_d = W_IDLE;
            default:   wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        axi_AR_READY = !rst && (rd_state_q == R_IDLE);
        axi_AW_READY = !rst && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_W);
        axi_W_READY  = !rst && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_AW);
        axi_R_VALID  = (rd_state_q == R_RESP);
        axi_B_VALID  = (wr_state_q == W_RESP);
        wr_mem       = (wr_state_q == W_MEM);
        rd_issue     = (rd_state_q == R_WAIT) && (rd_cnt_q == 4'd0) && !wr_mem;
        oob_err      = (rd_issue && !rd_ok_q) || (wr_mem && !wr_ok_q);
        mem_en       = (wr_mem && wr_ok_q) || (rd_issue && rd_ok_q);
        mem_addr     = wr_mem ? wr_idx_q : rd_idx_q;
        axi_R_DATA   = rd_ok_q ? mem_rdata : '0;
    end

    sram_sp_bw #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (mem_en),
        .we_i    (wr_mem),
        .addr_i  (mem_addr),
        .wdata_i (wr_data_q),
        .be_i    (wr_strb_q),
        .rdata_o (mem_rdata)
    );

endmodule
